// File: rtl/shared_resource_pipeline_n.sv
// ---------------------------------------------------------------------------
// shared_resource_pipeline_n
//
// N-channel front end for a shared, fixed-latency compute resource. Each
// channel owns a small input FIFO with valid/ready handshaking. A round-robin
// arbiter moves one buffered entry per cycle into the shared resource, which
// computes f(x) = (x << 1) + 1. Each result comes back on the output valid of
// the channel it was tagged with. A per-channel flush empties that channel's
// FIFO and kills its in-flight work.
//
// Optional feature macro: SRP_PERF_CNT_EN
//   defined     -> 16-bit saturating grant counter per channel on perf_grant_cnt
//   not defined -> no counter logic, perf_grant_cnt tied to 0
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   global_stall   in   freezes pushes, grants and resource stages
//   in_valid       in   [NUM_CH]          per-channel input valid
//   in_data        in   [NUM_CH*DATA_W]   channel i at [i*DATA_W +: DATA_W]
//   flush          in   [NUM_CH]          per-channel flush
//   in_ready       out  [NUM_CH]          channel FIFO can accept this cycle
//   out_stall      out  [NUM_CH]          complement of in_ready
//   out_valid      out  [NUM_CH]          result valid for channel i
//   out_data       out  [NUM_CH*DATA_W]   per-channel result, holds when idle
//   perf_grant_cnt out  [NUM_CH*16]       per-channel grant counters
// ---------------------------------------------------------------------------
module shared_resource_pipeline_n #(
   parameter int NUM_CH    = 2,
   parameter int DATA_W    = 32,
   parameter int BUF_DEPTH = 4,
   parameter int RES_LAT   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     global_stall,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        flush,
   output logic [NUM_CH-1:0]        in_ready,
   output logic [NUM_CH-1:0]        out_stall,
   output logic [NUM_CH-1:0]        out_valid,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [NUM_CH*16-1:0]     perf_grant_cnt
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TAG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int LAST  = RES_LAT - 1;

   logic [DATA_W-1:0] fifo_mem_q [NUM_CH][BUF_DEPTH];
   logic [DATA_W-1:0] fifo_mem_d [NUM_CH][BUF_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
   logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
   logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
   logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
   logic [CNT_W-1:0]  count_q  [NUM_CH];
   logic [CNT_W-1:0]  count_d  [NUM_CH];
   logic [TAG_W-1:0]  last_grant_q;
   logic [TAG_W-1:0]  last_grant_d;

   logic [RES_LAT-1:0] stg_valid_q;
   logic [RES_LAT-1:0] stg_valid_d;
   logic [TAG_W-1:0]   stg_tag_q  [RES_LAT];
   logic [TAG_W-1:0]   stg_tag_d  [RES_LAT];
   logic [DATA_W-1:0]  stg_data_q [RES_LAT];
   logic [DATA_W-1:0]  stg_data_d [RES_LAT];

   logic [DATA_W-1:0] out_hold_q [NUM_CH];
   logic [DATA_W-1:0] out_hold_d [NUM_CH];

   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] req;
   logic              grant_vld;
   logic [TAG_W-1:0]  grant_idx;
   logic [DATA_W-1:0] grant_data;

   // Handshake and request qualification. in_ready comes only from the
   // registered count, so a full FIFO refuses a push even if it pops in the
   // same cycle. A flushed channel neither pushes nor requests.
   always_comb begin
      in_ready = '0;
      push     = '0;
      req      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         in_ready[i] = (count_q[i] != CNT_W'(BUF_DEPTH)) && !global_stall;
         push[i]     = in_valid[i] && in_ready[i] && !flush[i];
         req[i]      = (count_q[i] != '0) && !flush[i] && !global_stall;
      end
   end

   assign out_stall = ~in_ready;

   // Round-robin arbiter. The scan runs from the farthest candidate to the
   // nearest, so the channel closest after last_grant overwrites the others.
   always_comb begin
      int cand;
      cand       = 0;
      grant_vld  = 1'b0;
      grant_idx  = '0;
      for (int off = NUM_CH; off >= 1; off--) begin
         cand = int'(last_grant_q) + off;
         if (cand >= NUM_CH) begin
            cand = cand - NUM_CH;
         end
         if (req[TAG_W'(cand)]) begin
            grant_vld = 1'b1;
            grant_idx = TAG_W'(cand);
         end
      end
      grant_data = fifo_mem_q[grant_idx][rd_ptr_q[grant_idx]];
   end

   // FIFO bookkeeping and arbiter pointer. Flush resets the pointers last, so
   // it overrides any same-cycle push or pop on that channel.
   always_comb begin
      logic pop;
      pop          = 1'b0;
      fifo_mem_d   = fifo_mem_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      last_grant_d = grant_vld ? grant_idx : last_grant_q;
      for (int i = 0; i < NUM_CH; i++) begin
         pop = grant_vld && (grant_idx == TAG_W'(i));
         if (push[i]) begin
            fifo_mem_d[i][wr_ptr_q[i]] = in_data[i*DATA_W +: DATA_W];
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
         end
         count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop);
         if (flush[i]) begin
            rd_ptr_d[i] = '0;
            wr_ptr_d[i] = '0;
            count_d[i]  = '0;
         end
      end
   end

   // Shared resource pipeline. Stage 0 computes f(x); the remaining stages just
   // carry the result. The whole pipe holds under global_stall, but the flush
   // kill is applied afterwards so it also works while stalled.
   always_comb begin
      stg_valid_d = stg_valid_q;
      stg_tag_d   = stg_tag_q;
      stg_data_d  = stg_data_q;
      if (!global_stall) begin
         stg_valid_d[0] = grant_vld;
         stg_tag_d[0]   = grant_idx;
         stg_data_d[0]  = {grant_data[DATA_W-2:0], 1'b1};
         for (int s = 1; s < RES_LAT; s++) begin
            stg_valid_d[s] = stg_valid_q[s-1];
            stg_tag_d[s]   = stg_tag_q[s-1];
            stg_data_d[s]  = stg_data_q[s-1];
         end
      end
      for (int s = 0; s < RES_LAT; s++) begin
         if (flush[stg_tag_d[s]]) begin
            stg_valid_d[s] = 1'b0;
         end
      end
   end

   // Output steering. The last stage drives only its tagged channel; every
   // other channel shows its held value from the last result it received.
   always_comb begin
      out_valid  = '0;
      out_data   = '0;
      out_hold_d = out_hold_q;
      for (int i = 0; i < NUM_CH; i++) begin
         out_data[i*DATA_W +: DATA_W] = out_hold_q[i];
         if (stg_valid_q[LAST] && !global_stall && (stg_tag_q[LAST] == TAG_W'(i))) begin
            out_valid[i]                 = 1'b1;
            out_data[i*DATA_W +: DATA_W] = stg_data_q[LAST];
            out_hold_d[i]                = stg_data_q[LAST];
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= TAG_W'(NUM_CH - 1);
         stg_valid_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            rd_ptr_q[i]   <= '0;
            wr_ptr_q[i]   <= '0;
            count_q[i]    <= '0;
            out_hold_q[i] <= '0;
         end
         for (int s = 0; s < RES_LAT; s++) begin
            stg_tag_q[s]  <= '0;
            stg_data_q[s] <= '0;
         end
      end else begin
         last_grant_q <= last_grant_d;
         stg_valid_q  <= stg_valid_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         out_hold_q   <= out_hold_d;
         stg_tag_q    <= stg_tag_d;
         stg_data_q   <= stg_data_d;
      end
   end

   // FIFO storage needs no reset; the pointers decide what is valid.
   always_ff @(posedge clk) begin
      fifo_mem_q <= fifo_mem_d;
   end

`ifdef SRP_PERF_CNT_EN
   logic [15:0] perf_cnt_q [NUM_CH];
   logic [15:0] perf_cnt_d [NUM_CH];

   // Saturating grant counters. Grants never happen under stall, so the
   // counters hold there without extra gating. Flush does not clear them.
   always_comb begin
      perf_cnt_d     = perf_cnt_q;
      perf_grant_cnt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_vld && (grant_idx == TAG_W'(i)) && (perf_cnt_q[i] != 16'hFFFF)) begin
            perf_cnt_d[i] = perf_cnt_q[i] + 16'd1;
         end
         perf_grant_cnt[i*16 +: 16] = perf_cnt_q[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            perf_cnt_q[i] <= '0;
         end
      end else begin
         perf_cnt_q <= perf_cnt_d;
      end
   end
`else
   assign perf_grant_cnt = '0;
`endif

endmodule
